mips_multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Each cycle it decodes opcode/funct and drives the 4-bit ALU operation select, the datapath muxes and the enables.
- It consumes the ALU zero flag to resolve BEQ/BNE.
- It paces instruction fetch and data memory access with a mem_ready handshake.

---
 rtl/mips_multicycle_control.sv | 224 ++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: decodes opcode/funct into ALU, mux and enable controls.
// Outputs are combinational from state (plus mem_ready/alu_zero/funct); FETCH, MEMRD and MEMWR wait on mem_ready.
module mips_multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADDR = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDIEX  = 4'd11,
        S_ADDIWB  = 4'd12,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    state_t cur_state;
    state_t nxt_state;
    // LW/SW choice is captured in DECODE so MEMADDR ignores later opcode changes.
    logic   is_lw_q;
    logic   is_lw_d;
    logic   funct_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= S_RST;
            is_lw_q   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            is_lw_q   <= is_lw_d;
        end
    end

    assign state = cur_state;

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt_state  = S_RST;
        is_lw_d    = is_lw_q;
        alu_op     = 4'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        case (cur_state)
            S_RST: begin
                nxt_state = S_FETCH;
            end
            S_FETCH: begin
                iord      = 1'b0;
                mem_read  = 1'b1;
                alu_src_a = 1'b0;
                alu_src_b = 2'd1;
                alu_op    = ALU_ADD;
                pc_src    = 2'd0;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 1'b0;
                alu_src_b = 2'd3;
                alu_op    = ALU_ADD;
                is_lw_d   = (opcode == OP_LW);
                case (opcode)
                    OP_LW, OP_SW:    nxt_state = S_MEMADDR;
                    OP_BEQ, OP_BNE:  nxt_state = S_BRANCH;
                    OP_J:            nxt_state = S_JUMP;
                    OP_ADDI:         nxt_state = S_ADDIEX;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            nxt_state = S_EXEC;
                        end else begin
                            illegal   = 1'b1;
                            nxt_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                        end
                    end
                    default: begin
                        illegal   = 1'b1;
                        nxt_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                nxt_state = is_lw_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                mem_read  = 1'b1;
                nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b0;
                nxt_state  = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd0;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_AND;
                endcase
                nxt_state = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                mem_to_reg = 1'b0;
                nxt_state  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd0;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                // BNE inverts the equality test; anything else is treated as BEQ.
                pc_write  = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = 2'd2;
                pc_write  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = ALU_ADD;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                nxt_state  = S_FETCH;
            end
            S_HALT: begin
                nxt_state = HALT_ON_ILLEGAL ? S_HALT : S_RST;
            end
            default: begin
                nxt_state = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed spec scenarios then randomized instruction streams vs a path-based model.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;

    logic [3:0] alu_op0, alu_op1;
    logic       alu_src_a0, alu_src_a1;
    logic [1:0] alu_src_b0, alu_src_b1;
    logic       iord0, iord1, mem_read0, mem_read1, mem_write0, mem_write1;
    logic       ir_write0, ir_write1, pc_write0, pc_write1;
    logic [1:0] pc_src0, pc_src1;
    logic       reg_write0, reg_write1, reg_dst0, reg_dst1;
    logic       mem_to_reg0, mem_to_reg1, illegal0, illegal1;
    logic [3:0] st0, st_h;

    mips_multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .alu_op(alu_op0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .iord(iord0), .mem_read(mem_read0), .mem_write(mem_write0),
        .ir_write(ir_write0), .pc_write(pc_write0), .pc_src(pc_src0),
        .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
        .illegal(illegal0), .state(st0)
    );

    mips_multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .alu_op(alu_op1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
        .iord(iord1), .mem_read(mem_read1), .mem_write(mem_write1),
        .ir_write(ir_write1), .pc_write(pc_write1), .pc_src(pc_src1),
        .reg_write(reg_write1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
        .illegal(illegal1), .state(st_h)
    );

    always #5 clock = ~clock;

    logic [17:0] outs0, outs1;
    assign outs0 = {alu_op0, alu_src_a0, alu_src_b0, iord0, mem_read0, mem_write0,
                    ir_write0, pc_write0, pc_src0, reg_write0, reg_dst0, mem_to_reg0, illegal0};
    assign outs1 = {alu_op1, alu_src_a1, alu_src_b1, iord1, mem_read1, mem_write1,
                    ir_write1, pc_write1, pc_src1, reg_write1, reg_dst1, mem_to_reg1, illegal1};

    int ntests = 0;
    int nfail  = 0;

    // Model: current state number plus the remaining states of the instruction in flight.
    logic [3:0] mstate;
    logic [3:0] mpath[$];
    logic       h_halted;
    logic [5:0] cur_op;
    logic [5:0] cur_fn;
    int         zsel = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08: return 1'b1;
            6'h00: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'd2;
            6'h22:   return 4'd6;
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h2A:   return 4'd7;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [17:0] exp_outs(input logic [3:0] st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z, input logic rdy);
        logic [3:0] aop;
        logic [1:0] sb, pcs;
        logic       sa, io, mr, mw, irw, pcw, rw, rd, m2r, ill;
        aop = 4'd0; sb = 2'd0; pcs = 2'd0; sa = 1'b0; io = 1'b0; mr = 1'b0; mw = 1'b0;
        irw = 1'b0; pcw = 1'b0; rw = 1'b0; rd = 1'b0; m2r = 1'b0; ill = 1'b0;
        case (st)
            4'd1:  begin mr = 1'b1; sb = 2'd1; aop = 4'd2; irw = rdy; pcw = rdy; end
            4'd2:  begin sb = 2'd3; aop = 4'd2; ill = !is_legal(op, fn); end
            4'd3:  begin sa = 1'b1; sb = 2'd2; aop = 4'd2; end
            4'd4:  begin io = 1'b1; mr = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; end
            4'd6:  begin io = 1'b1; mw = 1'b1; end
            4'd7:  begin sa = 1'b1; aop = alu_of(fn); end
            4'd8:  begin rw = 1'b1; rd = 1'b1; end
            4'd9:  begin sa = 1'b1; aop = 4'd6; pcs = 2'd1; pcw = (op == 6'h05) ? !z : z; end
            4'd10: begin pcs = 2'd2; pcw = 1'b1; end
            4'd11: begin sa = 1'b1; sb = 2'd2; aop = 4'd2; end
            4'd12: begin rw = 1'b1; end
            default: ;
        endcase
        return {aop, sa, sb, io, mr, mw, irw, pcw, pcs, rw, rd, m2r, ill};
    endfunction

    task automatic model_step(input logic rst, input logic rdy, input logic [5:0] op, input logic [5:0] fn);
        if (rst) begin
            mstate = 4'd0;
            mpath.delete();
        end else begin
            case (mstate)
                4'd0: mstate = 4'd1;
                4'd1: if (rdy) mstate = 4'd2;
                4'd2: begin
                    mpath.delete();
                    case (op)
                        6'h23:        mpath = '{4'd3, 4'd4, 4'd5};
                        6'h2B:        mpath = '{4'd3, 4'd6};
                        6'h00:        mpath = '{4'd7, 4'd8};
                        6'h04, 6'h05: mpath = '{4'd9};
                        6'h02:        mpath = '{4'd10};
                        6'h08:        mpath = '{4'd11, 4'd12};
                        default:      mpath.delete();
                    endcase
                    if (!is_legal(op, fn)) mpath.delete();
                    mstate = (mpath.size() != 0) ? mpath.pop_front() : 4'd1;
                end
                4'd4, 4'd6: if (rdy) mstate = (mpath.size() != 0) ? mpath.pop_front() : 4'd1;
                default: mstate = (mpath.size() != 0) ? mpath.pop_front() : 4'd1;
            endcase
        end
    endtask

    // One clock: drive at negedge, compare both DUTs with the model, advance at posedge.
    task automatic cycle(input logic rst, input logic rdy);
        logic [17:0] e;
        logic        hnext;
        @(negedge clock);
        reset     = rst;
        mem_ready = rdy;
        alu_zero  = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
        if (mstate == 4'd2 || mstate == 4'd7 || mstate == 4'd9) begin
            opcode = cur_op;
            funct  = cur_fn;
        end else begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
        end
        #1;
        e = exp_outs(mstate, opcode, funct, alu_zero, mem_ready);
        check("state", {28'd0, st0}, {28'd0, mstate});
        check("outputs", {14'd0, outs0}, {14'd0, e});
        check("h_state", {28'd0, st_h}, h_halted ? 32'd15 : {28'd0, mstate});
        check("h_outputs", {14'd0, outs1}, h_halted ? 32'd0 : {14'd0, e});
        check("rw_excl", {31'd0, mem_read0 & mem_write0}, 32'd0);
        hnext = h_halted;
        if (rst) hnext = 1'b0;
        else if (mstate == 4'd2 && !is_legal(opcode, funct)) hnext = 1'b1;
        model_step(rst, rdy, opcode, funct);
        h_halted = hnext;
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int exp_cycles);
        int n;
        n = 0;
        cur_op = op;
        cur_fn = fn;
        do begin
            cycle(1'b0, 1'b1);
            n++;
        end while (st0 !== 4'd1 && n < 50);
        check("instr_cycles", 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 6'd0; funct = 6'd0;
        cur_op = 6'd0; cur_fn = 6'h20;
        repeat (2) @(posedge clock);
        #1;
        mstate = 4'd0;
        h_halted = 1'b0;

        check("reset_state", {28'd0, st0}, 32'd0);
        check("reset_outs", {14'd0, outs0}, 32'd0);
        cycle(1'b0, 1'b1);
        check("rst_to_fetch", {28'd0, st0}, 32'd1);

        // R-type SUB walk-through
        cur_op = 6'h00; cur_fn = 6'h22;
        cycle(1'b0, 1'b1); check("sub_decode", {28'd0, st0}, 32'd2);
        cycle(1'b0, 1'b1); check("sub_exec", {28'd0, st0}, 32'd7);
        check("sub_aluop", {28'd0, alu_op0}, 32'd6);
        cycle(1'b0, 1'b1); check("sub_rwb", {28'd0, st0}, 32'd8);
        check("sub_rwb_ctl", {30'd0, reg_write0, reg_dst0}, 32'd3);
        cycle(1'b0, 1'b1); check("sub_back", {28'd0, st0}, 32'd1);

        // Cycle counts with mem_ready held high
        run_instr(6'h00, 6'h20, 4);
        run_instr(6'h00, 6'h24, 4);
        run_instr(6'h00, 6'h25, 4);
        run_instr(6'h00, 6'h2A, 4);
        run_instr(6'h23, 6'h00, 5);
        run_instr(6'h2B, 6'h00, 4);
        run_instr(6'h04, 6'h00, 3);
        run_instr(6'h05, 6'h00, 3);
        run_instr(6'h02, 6'h00, 3);
        run_instr(6'h08, 6'h00, 4);

        // LW with three wait cycles in MEMRD
        cur_op = 6'h23;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("lw_memrd", {28'd0, st0}, 32'd4);
            check("lw_memrd_ctl", {30'd0, iord0, mem_read0}, 32'd3);
            cycle(1'b0, (i == 3) ? 1'b1 : 1'b0);
        end
        check("lw_memwb", {28'd0, st0}, 32'd5);
        check("lw_m2r", {31'd0, mem_to_reg0}, 32'd1);
        cycle(1'b0, 1'b1);

        // Branch resolution for BEQ/BNE with both zero flags
        for (int b = 0; b < 4; b++) begin
            cur_op = (b < 2) ? 6'h04 : 6'h05;
            zsel = b % 2;
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b1);
            check("br_state", {28'd0, st0}, 32'd9);
            check("br_pcwrite", {31'd0, pc_write0}, (b < 2) ? 32'(b % 2) : 32'(1 - b % 2));
            check("br_pcsrc", {30'd0, pc_src0}, 32'd1);
            cycle(1'b0, 1'b1);
        end
        zsel = -1;

        // FETCH stalls two cycles
        cur_op = 6'h08;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0);
            check("fetch_wait", {28'd0, st0}, 32'd1);
            check("fetch_wait_ctl", {30'd0, pc_write0, ir_write0}, 32'd0);
        end
        run_instr(6'h08, 6'h00, 4);

        // Reset held two cycles from inside MEMRD
        cur_op = 6'h23;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("pre_rst_memrd", {28'd0, st0}, 32'd4);
        cycle(1'b1, 1'b0);
        check("rst_mid_state", {28'd0, st0}, 32'd0);
        check("rst_mid_outs", {14'd0, outs0}, 32'd0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("rst_mid_fetch", {28'd0, st0}, 32'd1);

        // Illegal opcode: one instance continues, the other parks in HALT
        cur_op = 6'h3F;
        cycle(1'b0, 1'b1);
        check("ill_decode", {28'd0, st0}, 32'd2);
        cycle(1'b0, 1'b1);
        check("ill_continue", {28'd0, st0}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("halt_hold", {28'd0, st_h}, 32'd15);
            cycle(1'b0, 1'($urandom_range(0, 1)));
        end
        cycle(1'b1, 1'b1);
        check("halt_reset", {28'd0, st_h}, 32'd0);
        cycle(1'b0, 1'b1);
        check("halt_refetch", {28'd0, st_h}, 32'd1);

        // Randomized instruction stream with random stalls and occasional resets
        for (int n = 0; n < 3000; n++) begin
            if (mstate == 4'd1) begin
                case ($urandom_range(0, 11))
                    0:  begin cur_op = 6'h00; cur_fn = 6'h20; end
                    1:  begin cur_op = 6'h00; cur_fn = 6'h22; end
                    2:  begin cur_op = 6'h00; cur_fn = 6'h24; end
                    3:  begin cur_op = 6'h00; cur_fn = 6'h25; end
                    4:  begin cur_op = 6'h00; cur_fn = 6'h2A; end
                    5:  begin cur_op = 6'h23; cur_fn = 6'($urandom); end
                    6:  begin cur_op = 6'h2B; cur_fn = 6'($urandom); end
                    7:  begin cur_op = ($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05; cur_fn = 6'($urandom); end
                    8:  begin cur_op = 6'h02; cur_fn = 6'($urandom); end
                    9:  begin cur_op = 6'h08; cur_fn = 6'($urandom); end
                    10: begin cur_op = 6'h00; cur_fn = 6'($urandom); end
                    default: begin cur_op = 6'($urandom); cur_fn = 6'($urandom); end
                endcase
            end
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
